// File: rtl/bcd_onehot_decoder.sv
// bcd_onehot_decoder: BCD-to-one-hot decoder behind a 2-entry result FIFO, with a saturating invalid-code counter.
// The counter is built only when BCD_DEC_ERR_CNT_EN is defined; otherwise err_cnt reads 0 and err_cnt_clr is ignored.
module bcd_onehot_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_bcd,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [9:0]       out_onehot,
    output logic             out_err,
    input  logic             err_cnt_clr,
    output logic [CNT_W-1:0] err_cnt
);
    logic [10:0] mem_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  occ_q, occ_d;
    logic [10:0] dec;
    logic        push, pop;
    always_comb begin
        dec       = (in_bcd < 4'd10) ? {1'b0, 10'(1) << in_bcd} : {1'b1, 10'b0};
        in_ready  = occ_q != 2'd2;
        out_valid = occ_q != 2'd0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        occ_d     = occ_q + 2'(push) - 2'(pop);
        // Gate the read so an empty FIFO never exposes stale storage
        {out_err, out_onehot} = out_valid ? mem_q[rd_ptr_q] : 11'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= 11'b0;
            mem_q[1] <= 11'b0;
        end else begin
            occ_q <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= dec;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end
`ifdef BCD_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_inc;
    always_comb begin
        err_inc   = push & dec[10];
        err_cnt_d = err_cnt_clr ? CNT_W'(err_inc) :
                    (err_inc && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end
    assign err_cnt = err_cnt_q;
`else
    logic unused_clr;
    assign unused_clr = err_cnt_clr;
    assign err_cnt    = '0;
`endif
endmodule

// File: tb/tb_bcd_onehot_decoder.sv
// tb_bcd_onehot_decoder: directed checks of decode, FIFO flow control, error counter and reset.
// Counter expectations follow BCD_DEC_ERR_CNT_EN so the bench serves both builds.
module tb_bcd_onehot_decoder;
`ifdef BCD_DEC_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_bcd = 4'd0;
    logic       in_ready, out_valid, out_err;
    logic       out_ready = 1'b0;
    logic [9:0] out_onehot;
    logic       err_cnt_clr = 1'b0;
    logic [1:0] err_cnt;
    int pass_cnt = 0;
    int total = 0;
    logic [9:0] sweep_exp [16] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                                   10'h040, 10'h080, 10'h100, 10'h200, 10'h000, 10'h000,
                                   10'h000, 10'h000, 10'h000, 10'h000};
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    bcd_onehot_decoder #(.CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bcd(in_bcd), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot), .out_err(out_err),
        .err_cnt_clr(err_cnt_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got %h want %h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #2;
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_onehot", 16'(out_onehot), 16'd0);
        chk("rst_err", 16'(out_err), 16'd0);
        chk("rst_err_cnt", 16'(err_cnt), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sweep();
        out_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                chk($sformatf("sweep_valid[%0d]", k-1), 16'(out_valid), 16'd1);
                chk($sformatf("sweep_onehot[%0d]", k-1), 16'(out_onehot), 16'(sweep_exp[k-1]));
                chk($sformatf("sweep_err[%0d]", k-1), 16'(out_err), 16'(k-1 >= 10));
            end
            if (k < 16) begin
                chk($sformatf("sweep_in_ready[%0d]", k), 16'(in_ready), 16'd1);
                in_valid = 1'b1;
                in_bcd   = 4'(k);
            end else in_valid = 1'b0;
            tick();
        end
        chk("sweep_drained", 16'(out_valid), 16'd0);
        chk("sweep_err_cnt", 16'(err_cnt), ERR_EN ? 16'd3 : 16'd0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_bcd = 4'd3;
        chk("bp_ready0", 16'(in_ready), 16'd1);
        tick();
        in_bcd = 4'd7;
        chk("bp_ready1", 16'(in_ready), 16'd1);
        chk("bp_head1", 16'(out_onehot), 16'h008);
        tick();
        in_bcd = 4'd5;
        chk("bp_ready2", 16'(in_ready), 16'd0);
        chk("bp_hold2", 16'(out_onehot), 16'h008);
        tick();
        chk("bp_ready3", 16'(in_ready), 16'd0);
        chk("bp_hold3", 16'(out_onehot), 16'h008);
        out_ready = 1'b1;
        tick();
        chk("bp_pop7", 16'(out_onehot), 16'h080);
        chk("bp_ready4", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_pop5", 16'(out_onehot), 16'h020);
        tick();
        chk("bp_empty", 16'(out_valid), 16'd0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] d [3] = '{4'd1, 4'd2, 4'd4};
        logic [9:0] e [3] = '{10'h002, 10'h004, 10'h010};
        out_ready = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) begin
                chk($sformatf("b2b_onehot[%0d]", k-1), 16'(out_onehot), 16'(e[k-1]));
                chk($sformatf("b2b_in_ready[%0d]", k-1), 16'(in_ready), 16'd1);
            end
            in_valid = k < 3;
            if (k < 3) in_bcd = d[k];
            tick();
        end
        chk("b2b_empty", 16'(out_valid), 16'd0);
    endtask

    task automatic test_err_cnt();
        out_ready = 1'b1;
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        chk("cnt_clr_idle", 16'(err_cnt), 16'd0);
        in_valid = 1'b1; in_bcd = 4'd12;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("cnt_sat[%0d]", k), 16'(err_cnt), ERR_EN ? 16'(sat_exp[k]) : 16'd0);
        end
        in_bcd = 4'd15; err_cnt_clr = 1'b1;
        tick();
        in_valid = 1'b0; err_cnt_clr = 1'b0;
        chk("cnt_clr_push", 16'(err_cnt), ERR_EN ? 16'd1 : 16'd0);
        chk("cnt_err_flag", 16'(out_err), 16'd1);
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_bcd = 4'd12;
        tick();
        in_bcd = 4'd13;
        tick();
        in_valid = 1'b0;
        chk("mid_full", 16'(in_ready), 16'd0);
        chk("mid_cnt", 16'(err_cnt), ERR_EN ? 16'd3 : 16'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 16'(out_valid), 16'd0);
        chk("mid_ready", 16'(in_ready), 16'd1);
        chk("mid_err_cnt", 16'(err_cnt), 16'd0);
        chk("mid_onehot", 16'(out_onehot), 16'd0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_bcd = 4'd9;
        #1 rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_first", 16'(out_onehot), 16'h200);
        tick();
        chk("post_stale_v", 16'(out_valid), 16'd0);
        tick();
        chk("post_stale_oh", 16'(out_onehot), 16'd0);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_back_to_back();
        test_err_cnt();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
